// File: rtl/apb_slave_regfile.sv
`default_nettype none
// ============================================================================
// Module   : apb_slave_regfile
// Brief    : APB4 completer, byte-strobed register file with wait states and
//            PSLVERR. Define APB_SLAVE_REGFILE_RO_ID_EN for a read-only ID word 0.
// Revision : 1.0 - initial release
// ============================================================================
module apb_slave_regfile #(
    parameter int          DATA_WIDTH  = 32,
    parameter int          ADDR_WIDTH  = 32,
    parameter int          DEPTH       = 16,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] ID_VALUE    = 32'hA9B0_0001
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
    output logic                    PREADY,
    output logic [DATA_WIDTH-1:0]   PRDATA,
    output logic                    PSLVERR
);

    localparam int                    c_LANES    = DATA_WIDTH / 8;
    localparam int                    c_OFF_W    = $clog2(c_LANES);
    localparam int                    c_IDX_W    = $clog2(DEPTH);
    localparam int                    c_HI_LSB   = c_IDX_W + c_OFF_W;
    localparam logic [ADDR_WIDTH-1:0] c_OFF_MASK = ADDR_WIDTH'((1 << c_OFF_W) - 1);
    localparam logic [3:0]            c_WAIT     = 4'(WAIT_STATES);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [3:0]              r_cnt;
    logic [3:0]              w_cnt_nxt;
    logic                    w_complete;
    logic [c_IDX_W-1:0]      w_idx;
    logic                    w_misaligned;
    logic                    w_out_of_range;
    logic                    w_ro_hit;
    logic                    w_err;
    logic                    w_wr_en;
    logic [DATA_WIDTH-1:0]   w_words [DEPTH];

    // ------------------------------------------------------------------------
    // Transfer FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_complete  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (PSEL && !PENABLE) begin
                    w_state_nxt = ST_ACCESS;
                    w_cnt_nxt   = c_WAIT;
                end
            end
            ST_ACCESS: begin
                if (!PSEL) begin
                    // Requester dropped the transfer: no write, no response.
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else if (!PENABLE) begin
                    // A fresh setup phase restarts the latency count.
                    w_cnt_nxt   = c_WAIT;
                end else if (r_cnt != 4'd0) begin
                    w_cnt_nxt   = r_cnt - 4'd1;
                end else begin
                    w_complete  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Address decode and error detection
    // ------------------------------------------------------------------------
    assign w_idx          = PADDR[c_HI_LSB-1:c_OFF_W];
    assign w_misaligned   = (PADDR & c_OFF_MASK) != '0;
    assign w_out_of_range = (PADDR >> c_HI_LSB) != '0;

`ifdef APB_SLAVE_REGFILE_RO_ID_EN
    assign w_ro_hit = PWRITE && (w_idx == '0);
`else
    assign w_ro_hit = 1'b0;
`endif

    assign w_err   = w_misaligned || w_out_of_range || w_ro_hit;
    assign w_wr_en = w_complete && PWRITE && !w_err;

    // ------------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------------
`ifdef APB_SLAVE_REGFILE_RO_ID_EN
    localparam int c_FIRST_RW = 1;
    assign w_words[0] = ID_VALUE[DATA_WIDTH-1:0];
`else
    localparam int c_FIRST_RW = 0;
    logic [31:0] w_unused_id;
    assign w_unused_id = ID_VALUE;
`endif

    for (genvar gi = c_FIRST_RW; gi < DEPTH; gi++) begin : g_word
        logic [DATA_WIDTH-1:0] r_word;

        always_ff @(posedge PCLK or negedge PRESETn) begin
            if (!PRESETn) begin
                r_word <= '0;
            end else if (w_wr_en && (w_idx == c_IDX_W'(gi))) begin
                for (int b = 0; b < c_LANES; b++) begin
                    if (PSTRB[b]) begin
                        r_word[8*b +: 8] <= PWDATA[8*b +: 8];
                    end
                end
            end
        end

        assign w_words[gi] = r_word;
    end

    // ------------------------------------------------------------------------
    // Response: everything is zero outside the completion cycle
    // ------------------------------------------------------------------------
    assign PREADY  = w_complete;
    assign PSLVERR = w_complete && w_err;
    assign PRDATA  = (w_complete && !PWRITE && !w_err) ? w_words[w_idx] : '0;

endmodule
`default_nettype wire

// File: tb/tb_apb_slave_regfile.sv
`default_nettype none
// Bench for apb_slave_regfile: two instances (0 and 4 wait states) driven with
// directed and random APB transfers, compared every cycle against a memory model.
module tb_apb_slave_regfile;

    localparam logic [31:0] ID = 32'hA9B0_0001;
`ifdef APB_SLAVE_REGFILE_RO_ID_EN
    localparam bit RO = 1'b1;
`else
    localparam bit RO = 1'b0;
`endif

    logic             clk;
    logic             rst_n;
    logic [1:0]       psel, penable, pwrite;
    logic [1:0][31:0] paddr, pwdata;
    logic [1:0][3:0]  pstrb;
    wire  [1:0]       pready, pslverr;
    wire  [1:0][31:0] prdata;

    apb_slave_regfile #(.WAIT_STATES(0)) u_dut0 (
        .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[0]), .PENABLE(penable[0]),
        .PWRITE(pwrite[0]), .PADDR(paddr[0]), .PWDATA(pwdata[0]), .PSTRB(pstrb[0]),
        .PREADY(pready[0]), .PRDATA(prdata[0]), .PSLVERR(pslverr[0])
    );

    apb_slave_regfile #(.WAIT_STATES(4)) u_dut1 (
        .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[1]), .PENABLE(penable[1]),
        .PWRITE(pwrite[1]), .PADDR(paddr[1]), .PWDATA(pwdata[1]), .PSTRB(pstrb[1]),
        .PREADY(pready[1]), .PRDATA(prdata[1]), .PSLVERR(pslverr[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state and per-DUT view of the transfer in flight
    logic [31:0] m_mem [2][16];
    int          t_acc [2];
    logic        t_wr  [2];
    logic [31:0] t_addr[2];
    int          n_checks = 0;
    int          n_err    = 0;
    bit          cmp_en   = 1'b0;

    function automatic int ws(input int d);
        return (d == 0) ? 0 : 4;
    endfunction

    function automatic bit m_err(input bit wr, input logic [31:0] a);
        return (a % 4 != 0) || (a >= 32'd64) || (RO && wr && (a / 4 == 0));
    endfunction

    function automatic logic [31:0] m_read(input int d, input logic [31:0] a);
        if (RO && (a / 4 == 0)) return ID;
        return m_mem[d][a / 4];
    endfunction

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        logic        ery, eerr;
        logic [31:0] erd;
        if (cmp_en) begin
            for (int d = 0; d < 2; d++) begin
                ery  = rst_n && (t_acc[d] == ws(d) + 1);
                eerr = ery && m_err(t_wr[d], t_addr[d]);
                erd  = (ery && !t_wr[d] && !eerr) ? m_read(d, t_addr[d]) : 32'h0;
                n_checks++;
                if ({pready[d], pslverr[d], prdata[d]} !== {ery, eerr, erd}) begin
                    n_err++;
                    $display("FAIL cycle dut%0d t=%0t: got ready=%b err=%b rdata=%h, expected ready=%b err=%b rdata=%h",
                             d, $time, pready[d], pslverr[d], prdata[d], ery, eerr, erd);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    // Starts in the cycle it is called (setup), returns in the cycle after completion
    task automatic xfer(input int d, input bit wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] st,
                        output logic [31:0] rd, output logic er, output int lat);
        psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr;
        paddr[d] = a; pwdata[d] = wd; pstrb[d] = st;
        t_wr[d] = wr; t_addr[d] = a; t_acc[d] = 0;
        lat = 0; rd = '0; er = 1'b0;
        for (int k = 1; k <= ws(d) + 1; k++) begin
            @(posedge clk); #1;
            penable[d] = 1'b1;
            t_acc[d]   = k;
            @(negedge clk);
            if (pready[d] && lat == 0) lat = k + 1;
            if (k == ws(d) + 1) begin
                rd = prdata[d];
                er = pslverr[d];
            end
        end
        @(posedge clk); #1;
        if (wr && !m_err(wr, a)) begin
            for (int b = 0; b < 4; b++)
                if (st[b]) m_mem[d][a / 4][8*b +: 8] = wd[8*b +: 8];
        end
        psel[d] = 1'b0; penable[d] = 1'b0; t_acc[d] = 0;
    endtask

    task automatic clear_model();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 16; i++) m_mem[d][i] = '0;
    endtask

    task automatic rand_run(input int d, input int n);
        logic [31:0] rd;
        logic        er;
        int          lat;
        for (int i = 0; i < n; i++) begin
            int          r;
            logic [31:0] a;
            r = $urandom_range(0, 9);
            a = 32'($urandom_range(0, 15)) * 4;
            if (r == 7) a = a + 32'($urandom_range(1, 3));
            else if (r == 8) a = 32'd64 + 32'($urandom_range(0, 63)) * 4;
            else if (r == 9) a = $urandom;
            xfer(d, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), rd, er, lat);
            if ($urandom_range(0, 3) == 0) idle(1);
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;

        rst_n = 1'b0;
        psel = '0; penable = '0; pwrite = '0; paddr = '0; pwdata = '0; pstrb = '0;
        for (int d = 0; d < 2; d++) begin
            t_acc[d] = 0; t_wr[d] = 1'b0; t_addr[d] = '0;
        end
        clear_model();
        @(posedge clk); #1;
        cmp_en = 1'b1;
        idle(2);
        rst_n = 1'b1;
        idle(1);

        // Zero-wait write then back-to-back read
        xfer(0, 1'b1, 32'h8, 32'hDEADBEEF, 4'hF, rd, er, lat);
        chk("wr0_latency", 32'(lat), 32'd2);
        chk("wr0_err", 32'(er), 32'd0);
        xfer(0, 1'b0, 32'h8, 32'h0, 4'h0, rd, er, lat);
        chk("rd0_latency", 32'(lat), 32'd2);
        chk("rd0_data", rd, 32'hDEADBEEF);
        chk("rd0_err", 32'(er), 32'd0);

        // Byte strobes
        xfer(0, 1'b1, 32'h4, 32'h11223344, 4'hF, rd, er, lat);
        xfer(0, 1'b1, 32'h4, 32'hAABBCCDD, 4'h5, rd, er, lat);
        xfer(0, 1'b0, 32'h4, 32'h0, 4'hF, rd, er, lat);
        chk("strb_data", rd, 32'h11BB33DD);
        xfer(0, 1'b1, 32'h4, 32'hFFFFFFFF, 4'h0, rd, er, lat);
        chk("strb0_err", 32'(er), 32'd0);
        xfer(0, 1'b0, 32'h4, 32'h0, 4'h0, rd, er, lat);
        chk("strb0_data", rd, 32'h11BB33DD);

        // Address errors
        xfer(0, 1'b1, 32'h2, 32'h01020304, 4'hF, rd, er, lat);
        chk("misalign_wr_err", 32'(er), 32'd1);
        xfer(0, 1'b1, 32'h40, 32'h01020304, 4'hF, rd, er, lat);
        chk("oor_wr_err", 32'(er), 32'd1);
        xfer(0, 1'b0, 32'h40, 32'h0, 4'h0, rd, er, lat);
        chk("oor_rd_err", 32'(er), 32'd1);
        chk("oor_rd_data", rd, 32'h0);
        for (int i = 0; i < 16; i++) xfer(0, 1'b0, 32'(i) * 4, 32'h0, 4'h0, rd, er, lat);
        xfer(0, 1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat);
        chk("word0_after_err", rd, RO ? ID : 32'h0);

        // Word 0: ID register or plain storage depending on build
        xfer(0, 1'b1, 32'h0, 32'h12345678, 4'hF, rd, er, lat);
        chk("w0_wr_err", 32'(er), RO ? 32'd1 : 32'd0);
        xfer(0, 1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat);
        chk("w0_rd_data", rd, RO ? 32'hA9B00001 : 32'h12345678);
        chk("w0_rd_err", 32'(er), 32'd0);

        // Wait states and abort on the 4-wait instance
        xfer(1, 1'b0, 32'hC, 32'h0, 4'h0, rd, er, lat);
        chk("ws4_latency", 32'(lat), 32'd6);
        xfer(1, 1'b1, 32'h10, 32'h55AA55AA, 4'hF, rd, er, lat);
        chk("ws4_wr_latency", 32'(lat), 32'd6);
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
        paddr[1] = 32'h10; pwdata[1] = 32'hFFFFFFFF; pstrb[1] = 4'hF;
        t_wr[1] = 1'b1; t_addr[1] = 32'h10; t_acc[1] = 0;
        for (int k = 1; k <= 2; k++) begin
            @(posedge clk); #1; penable[1] = 1'b1; t_acc[1] = k;
        end
        @(posedge clk); #1;
        psel[1] = 1'b0; penable[1] = 1'b0; t_acc[1] = 0;
        idle(1);
        xfer(1, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
        chk("abort_nowrite", rd, 32'h55AA55AA);

        // Reset in the middle of an access
        xfer(1, 1'b1, 32'h8, 32'h12345678, 4'hF, rd, er, lat);
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
        paddr[1] = 32'h8; pwdata[1] = 32'hCAFEF00D; pstrb[1] = 4'hF;
        t_wr[1] = 1'b1; t_addr[1] = 32'h8; t_acc[1] = 0;
        for (int k = 1; k <= 2; k++) begin
            @(posedge clk); #1; penable[1] = 1'b1; t_acc[1] = k;
        end
        rst_n = 1'b0;
        t_acc[1] = 0;
        clear_model();
        #1;
        chk("rst_ready", 32'(pready[1]), 32'd0);
        chk("rst_err", 32'(pslverr[1]), 32'd0);
        chk("rst_rdata", prdata[1], 32'h0);
        psel[1] = 1'b0; penable[1] = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(1);
        xfer(1, 1'b0, 32'h8, 32'h0, 4'h0, rd, er, lat);
        chk("post_rst_data", rd, 32'h0);
        chk("post_rst_err", 32'(er), 32'd0);

        // Random traffic
        rand_run(0, 300);
        rand_run(1, 150);
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 16; i++) xfer(d, 1'b0, 32'(i) * 4, 32'h0, 4'h0, rd, er, lat);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
